// File: rtl/ifetch_unit_if.sv
// ifetch_unit_if: instruction-memory and decode-side handshake bundle of the fetch stage.
interface ifetch_unit_if #(parameter int ADDR_W = 32);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [31:0]       imem_rdata;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] instr_pc;
    logic [ADDR_W-1:0] instr_pc4;
    logic              instr_valid;
    logic              instr_ready;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    modport master (
        output imem_req, imem_addr, instr, instr_pc, instr_pc4, instr_valid,
        input  imem_gnt, imem_rvalid, imem_rdata, instr_ready, redirect, redirect_pc
    );
    modport slave (
        input  imem_req, imem_addr, instr, instr_pc, instr_pc4, instr_valid,
        output imem_gnt, imem_rvalid, imem_rdata, instr_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/ifetch_unit.sv
// ifetch_unit: PC holder issuing single-outstanding imem fetches into a one-entry decode buffer.
module ifetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_3000
) (
    input logic          clk,
    input logic          reset,
    ifetch_unit_if.master bus
);
    typedef enum logic [2:0] {BOOT, FETCH, WAIT, FULL, SQUASH} state_e;
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, ipc_q, ipc_d, ipc4_q, ipc4_d;
    logic [31:0]       instr_q, instr_d;
    logic              latch;
    // A response racing a redirect belongs to the old stream and is never buffered.
    assign latch = state_q == WAIT && bus.imem_rvalid && !bus.redirect;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            ipc_q   <= '0;
            ipc4_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            ipc4_q  <= ipc4_d;
        end
    end
    always_comb begin
        state_d = state_q;
        pc_d    = latch ? pc_q + ADDR_W'(4) : pc_q;
        instr_d = latch ? bus.imem_rdata : instr_q;
        ipc_d   = latch ? pc_q : ipc_q;
        ipc4_d  = latch ? pc_q + ADDR_W'(4) : ipc4_q;
        case (state_q)
            BOOT:    state_d = FETCH;
            FETCH:   state_d = bus.imem_gnt ? WAIT : FETCH;
            WAIT:    state_d = bus.imem_rvalid ? FULL : WAIT;
            FULL:    state_d = bus.instr_ready ? FETCH : FULL;
            SQUASH:  state_d = bus.imem_rvalid ? FETCH : SQUASH;
            default: state_d = BOOT;
        endcase
        if (bus.redirect) begin
            pc_d = bus.redirect_pc & ~ADDR_W'(3);
            case (state_q)
                FETCH:   state_d = bus.imem_gnt ? SQUASH : FETCH;
                WAIT:    state_d = bus.imem_rvalid ? FETCH : SQUASH;
                SQUASH:  state_d = SQUASH;
                default: state_d = FETCH;
            endcase
        end
    end
    assign bus.imem_req    = state_q == FETCH;
    assign bus.imem_addr   = pc_q;
    assign bus.instr_valid = state_q == FULL;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = ipc_q;
    assign bus.instr_pc4   = ipc4_q;
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: random memory/decoder/redirect stimulus against a transaction-level fetch model.
module tb_ifetch_unit;
    logic clk = 0;
    logic reset = 0;
    always #5 clk = ~clk;
    ifetch_unit_if #(.ADDR_W(32)) bus();
    ifetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_3000)) dut (.clk(clk), .reset(reset), .bus(bus));
    int checks = 0, errors = 0;
    // model: boot cycle pending, request granted but unanswered, that answer stale, buffer full
    bit m_boot, m_out, m_stale, m_bv;
    logic [31:0] m_pc, m_instr, m_ipc;
    int k_gnt, k_lat, k_ready, k_redir;
    bit mem_busy;
    int mem_wait;
    int trig;
    logic [31:0] t_pc;
    bit fired, cap_arm, first_after, got_req, got_val, cap_v1, t1_log;
    logic [31:0] cap_addr, cap_pc, cap_pc4;
    int hold_n;
    logic [31:0] q_addr[$], q_pc[$];
    int q_vidx[$];
    int ncheck;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask
    function automatic bit m_req();
        return !m_boot && !m_out && !m_bv;
    endfunction
    task automatic model_reset();
        m_boot = 1; m_out = 0; m_stale = 0; m_bv = 0;
        m_pc = 32'h3000; m_instr = 0; m_ipc = 0;
    endtask
    task automatic model_step();
        bit req;
        req = m_req();
        if (!reset) model_reset();
        else if (bus.redirect) begin
            if (m_boot) m_boot = 0;
            else if (req && bus.imem_gnt) begin m_out = 1; m_stale = 1; end
            else if (m_out && !(bus.imem_rvalid && !m_stale)) m_stale = 1;
            else if (m_out) m_out = 0;
            m_bv = 0;
            m_pc = bus.redirect_pc & ~32'd3;
        end else if (m_boot) m_boot = 0;
        else if (req && bus.imem_gnt) begin m_out = 1; m_stale = 0; end
        else if (m_out && bus.imem_rvalid) begin
            if (!m_stale) begin
                m_instr = bus.imem_rdata; m_ipc = m_pc; m_pc = m_pc + 4; m_bv = 1;
            end
            m_out = 0; m_stale = 0;
        end else if (m_bv && bus.instr_ready) m_bv = 0;
    endtask
    task automatic check();
        ncheck++;
        chk("imem_req", 32'(bus.imem_req), 32'(m_req()));
        chk("imem_addr", bus.imem_addr, m_pc);
        chk("instr_valid", 32'(bus.instr_valid), 32'(m_bv));
        if (m_bv) begin
            chk("instr", bus.instr, m_instr);
            chk("instr_pc", bus.instr_pc, m_ipc);
            chk("instr_pc4", bus.instr_pc4, m_ipc + 4);
        end
        if (!reset) begin
            chk("rst_instr", bus.instr, 0);
            chk("rst_instr_pc", bus.instr_pc, 0);
            chk("rst_instr_pc4", bus.instr_pc4, 0);
        end
        if (hold_n > 0 && m_bv) begin
            chk("hold_pc", bus.instr_pc, 32'h300C);
            hold_n--;
        end
        if (t1_log) begin
            if (bus.imem_req) q_addr.push_back(bus.imem_addr);
            if (bus.instr_valid) begin q_pc.push_back(bus.instr_pc); q_vidx.push_back(ncheck); end
        end
        if (cap_arm) begin
            if (first_after) begin cap_v1 = bus.instr_valid; first_after = 0; end
            if (!got_req && bus.imem_req) begin got_req = 1; cap_addr = bus.imem_addr; end
            if (!got_val && bus.instr_valid) begin
                got_val = 1; cap_pc = bus.instr_pc; cap_pc4 = bus.instr_pc4;
            end
        end
    endtask
    task automatic drive();
        bit rv, g, rd;
        rv = 0;
        if (mem_busy) begin
            if (mem_wait == 0) begin rv = 1; mem_busy = 0; end
            else mem_wait--;
        end
        g = bus.imem_req && reset && ($urandom_range(99) < k_gnt);
        if (g) begin mem_busy = 1; mem_wait = $urandom_range(k_lat); end
        bus.imem_rvalid = rv;
        bus.imem_rdata  = $urandom;
        bus.imem_gnt    = g;
        bus.instr_ready = $urandom_range(99) < k_ready;
        rd = $urandom_range(99) < k_redir;
        bus.redirect_pc = $urandom;
        if ((trig == 1 && m_out && !m_stale && !rv) || (trig == 2 && m_out && !m_stale && rv) ||
            (trig == 3 && m_bv)) begin
            rd = 1; bus.redirect_pc = t_pc; trig = 0; fired = 1;
            if (m_bv) bus.instr_ready = 1;
            cap_arm = 1; first_after = 1; got_req = 0; got_val = 0;
        end
        if (rd && rv && m_stale) rd = 0;
        bus.redirect = rd;
    endtask
    task automatic step(input bit rst_v);
        @(negedge clk);
        check();
        drive();
        if (!rst_v && reset) begin
            reset = 0;
            #1;
            chk("async_req", 32'(bus.imem_req), 0);
            chk("async_valid", 32'(bus.instr_valid), 0);
            chk("async_addr", bus.imem_addr, 32'h3000);
        end else reset = rst_v;
        @(posedge clk);
        model_step();
    endtask
    task automatic run_trig(input int mode, input logic [31:0] pc, input string nm);
        int n = 0;
        trig = mode; t_pc = pc; fired = 0; cap_arm = 0;
        while (!(fired && got_req && got_val) && n < 200) begin step(1); n++; end
        if (!(fired && got_req && got_val)) begin
            chk({nm, "_timeout"}, 1, 0);
            trig = 0;
        end
    endtask
    initial begin
        bus.imem_gnt = 0; bus.imem_rvalid = 0; bus.imem_rdata = 0;
        bus.instr_ready = 0; bus.redirect = 0; bus.redirect_pc = 0;
        model_reset();
        k_gnt = 100; k_lat = 0; k_ready = 100; k_redir = 0;
        step(0); step(0);
        t1_log = 1; ncheck = 0;
        for (int i = 0; i < 11; i++) step(1);
        t1_log = 0;
        if (q_addr.size() >= 3 && q_pc.size() >= 3) begin
            chk("t1_addr0", q_addr[0], 32'h3000);
            chk("t1_addr1", q_addr[1], 32'h3004);
            chk("t1_addr2", q_addr[2], 32'h3008);
            chk("t1_pc0", q_pc[0], 32'h3000);
            chk("t1_pc1", q_pc[1], 32'h3004);
            chk("t1_pc2", q_pc[2], 32'h3008);
            chk("t1_first_valid", 32'(q_vidx[0]), 4);
            chk("t1_period", 32'(q_vidx[1] - q_vidx[0]), 3);
        end else chk("t1_count", 32'(q_pc.size()), 3);
        k_ready = 0; hold_n = 5;
        for (int i = 0; i < 12; i++) step(1);
        chk("t2_held_cycles", 32'(hold_n), 0);
        k_ready = 100; k_lat = 2;
        run_trig(1, 32'h0000_3100, "t3");
        chk("t3_addr", cap_addr, 32'h3100);
        chk("t3_pc", cap_pc, 32'h3100);
        k_lat = 0;
        run_trig(2, 32'h0000_3203, "t4");
        chk("t4_addr", cap_addr, 32'h3200);
        chk("t4_pc", cap_pc, 32'h3200);
        run_trig(3, 32'h0000_4000, "t5");
        chk("t5_valid_next", 32'(cap_v1), 0);
        chk("t5_addr", cap_addr, 32'h4000);
        chk("t5_pc", cap_pc, 32'h4000);
        run_trig(3, 32'hFFFF_FFFE, "wrap");
        chk("wrap_pc", cap_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", cap_pc4, 32'h0);
        begin
            int n = 0;
            k_lat = 3;
            while (!(m_out && !m_stale) && n < 50) begin step(1); n++; end
            chk("t6_reached_wait", 32'(m_out && !m_stale), 1);
            step(0); step(0);
            k_gnt = 0; mem_busy = 1; mem_wait = 1;
            step(1);
            cap_arm = 1; first_after = 1; got_req = 0; got_val = 0;
            for (int i = 0; i < 4; i++) step(1);
            chk("t6_stale_delivered", 32'(mem_busy), 0);
            k_gnt = 100; k_lat = 0; n = 0;
            while (!got_val && n < 50) begin step(1); n++; end
            chk("t6_pc", cap_pc, 32'h3000);
            cap_arm = 0;
        end
        k_gnt = 60; k_lat = 3; k_ready = 70; k_redir = 8;
        begin
            int rst_cnt = 0;
            for (int i = 0; i < 4000; i++) begin
                if (rst_cnt == 0 && $urandom_range(399) == 0) rst_cnt = 2;
                step(rst_cnt == 0);
                if (rst_cnt > 0) rst_cnt--;
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
